fib_result_checker: RTL and testbench

FIB_RESULT_CHECKER -- requirements
Module: fib_result_checker

---
 rtl/fib_result_checker_pkg.sv | 19 +
 rtl/fib_result_checker_if.sv | 21 ++
 rtl/fib_seq_gen.sv | 25 ++
 rtl/fib_result_checker.sv | 134 +++++++++++++
 tb/tb_fib_result_checker.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fib_result_checker_pkg.sv
// Shared definitions for the Fibonacci result checker: FSM encoding and
// default program/checker geometry.
package fib_result_checker_pkg;

    typedef enum logic [1:0] {
        WATCH,
        READ,
        CHECK,
        DONE
    } state_t;

    localparam int unsigned HALT_PC_DEFAULT        = 104;
    localparam int unsigned NUM_WORDS_DEFAULT      = 10;
    localparam int unsigned STABLE_CYCLES_DEFAULT  = 10;
    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 1000;

    localparam logic [7:0] NO_ERR_IDX = 8'hFF;

endpackage

// File: rtl/fib_result_checker_if.sv
// Data-memory read port: the checker issues single-cycle reads and the
// memory returns the word one cycle later.
interface fib_result_checker_if;

    logic        rd_en;
    logic [31:0] rd_addr;
    logic [31:0] rd_data;

    modport master (
        output rd_en,
        output rd_addr,
        input  rd_data
    );

    modport slave (
        input  rd_en,
        input  rd_addr,
        output rd_data
    );

endinterface

// File: rtl/fib_seq_gen.sv
// Fibonacci expected-value generator: value starts at 1 and steps through
// 1,1,2,3,5,... on each advance, wrapping modulo 2^32.
module fib_seq_gen (
    input  logic        clk,
    input  logic        rst,
    input  logic        advance,
    output logic [31:0] value
);

    logic [31:0] exp_prev;
    logic [31:0] exp_cur;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_prev <= '0;
            exp_cur  <= 32'd1;
        end else if (advance) begin
            exp_prev <= exp_cur;
            exp_cur  <= exp_prev + exp_cur;
        end
    end

    assign value = exp_cur;

endmodule

// File: rtl/fib_result_checker.sv
// Waits for the CPU to park at its halt loop, then reads back the result
// words and compares them against the Fibonacci sequence.
module fib_result_checker
    import fib_result_checker_pkg::*;
#(
    parameter int unsigned HALT_PC        = HALT_PC_DEFAULT,
    parameter int unsigned STABLE_CYCLES  = STABLE_CYCLES_DEFAULT,
    parameter int unsigned NUM_WORDS      = NUM_WORDS_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          pc,
    fib_result_checker_if.master mem,
    output logic                 done,
    output logic                 pass,
    output logic                 timeout,
    output logic [7:0]           err_count,
    output logic [7:0]           first_err_idx
);

    localparam int unsigned SC_W = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned CC_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t          state;
    state_t          state_next;
    logic [SC_W-1:0] stable_cnt;
    logic [CC_W-1:0] cyc_cnt;
    logic [7:0]      idx;
    logic [31:0]     exp_cur;

    logic at_halt;
    logic halt_seen;
    logic timed_out;
    logic mismatch;
    logic last_word;
    logic advance;
    logic finish_check;
    logic finish_timeout;

    fib_seq_gen u_gen (
        .clk     (clk),
        .rst     (rst),
        .advance (advance),
        .value   (exp_cur)
    );

    assign at_halt   = (pc == HALT_PC);
    assign halt_seen = at_halt && (stable_cnt == SC_W'(STABLE_CYCLES - 1));
    assign timed_out = (cyc_cnt == CC_W'(TIMEOUT_CYCLES - 1));
    assign mismatch  = (mem.rd_data != exp_cur);
    assign last_word = (idx == 8'(NUM_WORDS - 1));

    assign mem.rd_en   = (state == READ);
    assign mem.rd_addr = (state == READ) ? {22'd0, idx, 2'b00} : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= WATCH;
        end else begin
            state <= state_next;
        end
    end

    // Halt detection is tested before the timeout so a tie goes to READ.
    always_comb begin
        state_next     = state;
        advance        = 1'b0;
        finish_check   = 1'b0;
        finish_timeout = 1'b0;
        case (state)
            WATCH: begin
                if (halt_seen) begin
                    state_next = READ;
                end else if (timed_out) begin
                    state_next     = DONE;
                    finish_timeout = 1'b1;
                end
            end
            READ: state_next = CHECK;
            CHECK: begin
                if (last_word) begin
                    state_next   = DONE;
                    finish_check = 1'b1;
                end else begin
                    state_next = READ;
                    advance    = 1'b1;
                end
            end
            DONE:    state_next = DONE;
            default: state_next = WATCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stable_cnt    <= '0;
            cyc_cnt       <= '0;
            idx           <= '0;
            done          <= 1'b0;
            pass          <= 1'b0;
            timeout       <= 1'b0;
            err_count     <= '0;
            first_err_idx <= NO_ERR_IDX;
        end else begin
            if (state == WATCH) begin
                stable_cnt <= at_halt ? stable_cnt + SC_W'(1) : '0;
                cyc_cnt    <= cyc_cnt + CC_W'(1);
            end
            if (state == CHECK && mismatch) begin
                if (err_count != 8'hFF) begin
                    err_count <= err_count + 8'd1;
                end
                if (first_err_idx == NO_ERR_IDX) begin
                    first_err_idx <= idx;
                end
            end
            if (advance) begin
                idx <= idx + 8'd1;
            end
            if (finish_timeout) begin
                done    <= 1'b1;
                timeout <= 1'b1;
                pass    <= 1'b0;
            end
            // The final word's compare lands in the same edge as entry to DONE.
            if (finish_check) begin
                done <= 1'b1;
                pass <= (err_count == 8'd0) && !mismatch && !timeout;
            end
        end
    end

endmodule

// File: tb/tb_fib_result_checker.sv
// Directed-plus-random bench for fib_result_checker with a synchronous-read
// memory model and a bench-side Fibonacci reference table.
module tb_fib_result_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc  = 32'd0;
    logic        done;
    logic        pass;
    logic        timeout;
    logic [7:0]  err_count;
    logic [7:0]  first_err_idx;

    fib_result_checker_if bus ();

    fib_result_checker #(
        .HALT_PC        (104),
        .STABLE_CYCLES  (10),
        .NUM_WORDS      (10),
        .TIMEOUT_CYCLES (1000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pc            (pc),
        .mem           (bus.master),
        .done          (done),
        .pass          (pass),
        .timeout       (timeout),
        .err_count     (err_count),
        .first_err_idx (first_err_idx)
    );

    always #5 clk = ~clk;

    logic [31:0] ram [0:15];
    logic [31:0] fib_ref [0:9];

    // Data is only meaningful the cycle after a read; otherwise it is junk.
    always @(posedge clk) begin
        if (bus.rd_en) bus.rd_data <= ram[bus.rd_addr[5:2]];
        else           bus.rd_data <= 32'hDEAD_BEEF;
    end

    int          rd_pulses;
    logic        prev_en;
    logic        consec;
    logic [31:0] addr_q [$];

    always @(negedge clk) begin
        if (!rst) begin
            rd_pulses = 0;
            prev_en   = 1'b0;
            consec    = 1'b0;
            addr_q.delete();
        end else begin
            if (bus.rd_en) begin
                rd_pulses++;
                addr_q.push_back(bus.rd_addr);
                if (prev_en) consec = 1'b1;
            end
            prev_en = bus.rd_en;
        end
    end

    int checks = 0;
    int passed = 0;
    int run104 = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rd_en"}, 32'(bus.rd_en), 32'd0);
        check({tag, "_rd_addr"}, bus.rd_addr, 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_pass"}, 32'(pass), 32'd0);
        check({tag, "_timeout"}, 32'(timeout), 32'd0);
        check({tag, "_err_count"}, 32'(err_count), 32'd0);
        check({tag, "_first_err"}, 32'(first_err_idx), 32'hFF);
    endtask

    task automatic load_good_ram();
        for (int i = 0; i < 16; i++) ram[i] = (i < 10) ? fib_ref[i] : 32'h0BAD_0000;
    endtask

    task automatic model(output int errs, output int first);
        errs  = 0;
        first = 255;
        for (int i = 0; i < 10; i++) begin
            if (ram[i] !== fib_ref[i]) begin
                if (errs < 255) errs++;
                if (first == 255) first = i;
            end
        end
    endtask

    task automatic noise_step(input bit allow104);
        if (allow104 && run104 < 5 && $urandom_range(0, 7) == 0) begin
            pc = 32'd104;
            run104++;
        end else begin
            pc = $urandom;
            if (pc == 32'd104) pc = 32'd100;
            run104 = 0;
        end
    endtask

    task automatic noise(input int n, input bit allow104);
        for (int i = 0; i < n; i++) begin
            noise_step(allow104 && (i < n - 1));
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_rd(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.rd_en && lat < 100);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 100);
    endtask

    task automatic halt_and_finish(input string tag, input int exp_lat);
        int lat;
        int n;
        pc = 32'd104;
        wait_rd(lat);
        check({tag, "_halt_latency"}, 32'(lat), 32'(exp_lat));
        wait_done(n);
        check({tag, "_done_latency"}, 32'(n), 32'd20);
    endtask

    task automatic check_results(input string tag);
        int errs;
        int first;
        model(errs, first);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_pass"}, 32'(pass), 32'(errs == 0));
        check({tag, "_timeout"}, 32'(timeout), 32'd0);
        check({tag, "_err_count"}, 32'(err_count), 32'(errs));
        check({tag, "_first_err"}, 32'(first_err_idx), 32'(first));
        check({tag, "_rd_pulses"}, 32'(rd_pulses), 32'd10);
        check({tag, "_no_consec"}, 32'(consec), 32'd0);
    endtask

    initial begin
        int n;
        int lat;
        int k;
        int pos;
        logic [31:0] obs_addr;

        for (int i = 0; i < 10; i++) fib_ref[i] = (i < 2) ? 32'd1 : fib_ref[i-1] + fib_ref[i-2];
        load_good_ram();

        // Reset state
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");

        // Correct memory, halt after random pc activity
        rst = 1'b1;
        noise(20, 1'b1);
        halt_and_finish("good", 10);
        check_results("good");
        check("good_pass_literal", 32'(pass), 32'd1);
        for (int i = 0; i < 10; i++) begin
            obs_addr = (i < addr_q.size()) ? addr_q[i] : 32'hFFFF_FFFF;
            check($sformatf("good_rd_addr%0d", i), obs_addr, 32'(4 * i));
        end
        noise(30, 1'b1);
        check("done_sticky", 32'(done), 32'd1);
        check("done_pc_ignored", 32'(rd_pulses), 32'd10);
        check("done_pass_held", 32'(pass), 32'd1);

        // Two corrupted words
        ram[4] = 32'd6;
        ram[7] = 32'd0;
        do_reset();
        noise(15, 1'b1);
        halt_and_finish("corrupt", 10);
        check_results("corrupt");
        check("corrupt_err_literal", 32'(err_count), 32'd2);
        check("corrupt_first_literal", 32'(first_err_idx), 32'd4);

        // Random corruption patterns
        for (int t = 0; t < 4; t++) begin
            load_good_ram();
            k = $urandom_range(0, 4);
            for (int j = 0; j < k; j++) begin
                pos = $urandom_range(0, 9);
                ram[pos] = ram[pos] ^ ($urandom | 32'd1);
            end
            do_reset();
            noise($urandom_range(1, 40), 1'b1);
            halt_and_finish($sformatf("rand%0d", t), 10);
            check_results($sformatf("rand%0d", t));
        end

        // Glitch: nine cycles at halt, one away, then steady
        load_good_ram();
        do_reset();
        noise(10, 1'b1);
        pc = 32'd104;
        repeat (9) @(negedge clk);
        pc = 32'd108;
        @(negedge clk);
        check("glitch_no_early_read", 32'(rd_pulses), 32'd0);
        halt_and_finish("glitch", 10);
        check_results("glitch");

        // No halt ever: timeout after exactly TIMEOUT_CYCLES cycles
        do_reset();
        n = 0;
        do begin
            noise_step(1'b0);
            @(negedge clk);
            n++;
        end while (!done && n < 1100);
        check("to_cycle", 32'(n), 32'd1000);
        check("to_timeout", 32'(timeout), 32'd1);
        check("to_pass", 32'(pass), 32'd0);
        check("to_rd_pulses", 32'(rd_pulses), 32'd0);
        check("to_err_count", 32'(err_count), 32'd0);
        check("to_first_err", 32'(first_err_idx), 32'hFF);

        // Halt completes on the very cycle the timeout would fire
        do_reset();
        noise(990, 1'b1);
        pc = 32'd104;
        wait_rd(lat);
        check("tie_halt_latency", 32'(lat), 32'd10);
        check("tie_timeout", 32'(timeout), 32'd0);
        wait_done(n);
        check("tie_done_latency", 32'(n), 32'd20);
        check_results("tie");

        // Reset during the third CHECK, then a clean rerun
        ram[0] = 32'd77;
        do_reset();
        noise(12, 1'b1);
        pc = 32'd104;
        k = 0;
        n = 0;
        while (k < 3 && n < 200) begin
            @(negedge clk);
            n++;
            if (bus.rd_en) k++;
        end
        check("midrst_reached_third_read", 32'(k), 32'd3);
        @(negedge clk);
        check("midrst_err_before", 32'(err_count), 32'd1);
        rst = 1'b0;
        #1;
        check_reset_values("midrst");
        ram[0] = fib_ref[0];
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        halt_and_finish("midrst_rerun", 10);
        check_results("midrst_rerun");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
